gtx_rx_frame_monitor: RTL and testbench
=======================================

Name: gtx_rx_frame_monitor

Overview:
Parametrised per-fiber receive framer and link monitor for the DCFEB/GTX optical path. It runs in the recovered rx_clk160 domain and replaces the fixed 4-phase/48-bit capture with configurable word width and frame length. It finds and tracks frame alignment on K28.5 commas and assembles frame payloads. It runs a link-status state machine and keeps saturating error counters that the fabric-clock side samples.

Parameters:
WORD_W, 16, GTX parallel word width in bits (8 or 16 or 32); low byte holds the comma.
NWORDS, 4, words per frame: 1 comma word plus NWORDS-1 payload words; legal range 2..8.
CNT_W, 16, width of all error counters.
LOCK_FRAMES, 8, consecutive correctly placed commas needed to declare lock.
BAD_FRAMES, 4, consecutive bad frames that drop lock.

Ports:
rx_clk160  in  1  GTX recovered user clock; all logic on its rising edge
gtx_rx_reset  in  1  asynchronous active-high reset
ttc_resync  in  1  single-cycle pulse, already synchronous to rx_clk160; clears status and counters
rx_sync_done  in  1  GTX rxsync complete; low forces state IDLE
rx_word  in  WORD_W  received parallel word
rx_kchar  in  1  K-character flag for rx_word[7:0]
rx_notintable  in  1  8b10b not-in-table flag for this word
rx_disperr  in  1  8b10b disparity error flag for this word
en_prbs_test  in  1  PRBS test mode select
rx_valid  in  1  PRBS checker: compare is meaningful
rx_match  in  1  PRBS checker: compare matched
frame_data  out  (NWORDS-1)*WORD_W  assembled payload; first payload word in LSBs
frame_strobe  out  1  one-cycle pulse when frame_data updates
cew  out  NWORDS  one-hot phase of the word received in the previous cycle
link_good  out  1  state LOCKED
link_bad  out  1  lock was lost since last ttc_resync (sticky)
link_had_err  out  1  any word error since last ttc_resync (sticky)
err_count  out  CNT_W  bad-frame count, or PRBS mismatch count (see Optional Feature)
notintable_count  out  CNT_W  notintable word count
disperr_count  out  CNT_W  disparity-error word count

Behaviour:
- Reset is gtx_rx_reset, asynchronous, active-high. Clock is rx_clk160.
- Reset values: all outputs 0; state IDLE; phase counter 0; lock and bad counters 0.
- comma: rx_kchar=1 and rx_word[7:0]=8'hBC. word_err: rx_notintable or rx_disperr.
- Phase counter: 0..NWORDS-1; wraps to 0 after NWORDS-1.
- cew: registered one-hot of the phase counter.
- FSM transitions:
  - IDLE -> HUNT when rx_sync_done=1.
  - HUNT: a comma sets phase to 1 on the next word and lock_cnt to 1. At phase 0, a comma increments lock_cnt; a non-comma resets lock_cnt to 0 and re-hunts. Reaching lock_cnt=LOCK_FRAMES moves to LOCKED.
  - LOCKED: a frame is bad if the phase-0 word is not a comma, or if any word in the frame has word_err. Bad frames increment bad_cnt; a good frame clears it. bad_cnt=BAD_FRAMES moves to HUNT and sets link_bad.
  - Any state -> IDLE when rx_sync_done=0. This clears phase, lock_cnt and bad_cnt but does not touch counters or sticky flags.
- Payload: in LOCKED, word at phase k (1..NWORDS-1) goes to slot k-1 of a shadow register. After the phase NWORDS-1 word, frame_data loads from the shadow and frame_strobe pulses. Latency is 1 clock after the last payload word. frame_data holds between strobes and is not updated outside LOCKED.
- Counters: notintable_count and disperr_count increment per flagged word in any state except IDLE. Both flags on one word increment both. All counters saturate at all-ones, with no wrap.
- link_had_err sets on any word_err outside IDLE.
- ttc_resync clears all counters, link_bad and link_had_err. Clear wins over a same-cycle increment or set. ttc_resync does not change FSM state or alignment.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is discarded with no strobe.

Optional Feature:
Macro GTX_RX_PRBS_CHECK_EN.
- Defined: when en_prbs_test=1, err_count increments on each phase-0 cycle with rx_valid=1 and rx_match=0, in any non-IDLE state. Bad frames are then not counted. When en_prbs_test=0, err_count counts bad frames.
- Undefined: en_prbs_test, rx_valid and rx_match are ignored (tied to sump), and err_count always counts bad frames in LOCKED.

Test Plan:
- Acquire lock: NWORDS=4; reset, rx_sync_done=1; feed 8 frames of BC, 0x1111, 0x2222, 0x3333 -> link_good=1 after the 8th comma. frame_strobe then pulses every 4 clocks with frame_data=48'h333322221111, and cew cycles 0001, 0010, 0100, 1000.
- Lock loss: in LOCKED, replace 4 consecutive commas with 0x0000 -> link_good=0 and link_bad=1 after the 4th; err_count=4. Three bad frames then one good frame -> bad_cnt clears and lock is held.
- Error counters: inject rx_disperr on 3 words and both flags on 1 word -> disperr_count=4, notintable_count=1, link_had_err=1. Pulse ttc_resync in the same cycle as a disperr -> all counters 0 and flags 0.
- Saturation: CNT_W=4 override; inject 20 notintable words -> count holds at 4'hF.
- Reset mid-frame: assert gtx_rx_reset at phase 2 -> all outputs 0 asynchronously and no frame_strobe. After release, re-lock takes 8 frames.
- PRBS (macro defined): en_prbs_test=1, rx_valid=1, rx_match=0 for 5 frames -> err_count=5. With the macro undefined, the same stimulus gives err_count=0.

Source files
------------

// File: rtl/gtx_rx_frame_monitor_if.sv
// Bundle of the GTX receive-side inputs and frame/link-status outputs of gtx_rx_frame_monitor.
// The word stream is free-running with no back-pressure; frame_strobe marks the single cycle in which frame_data is new.
interface gtx_rx_frame_monitor_if #(
    parameter int WORD_W = 16,
    parameter int NWORDS = 4,
    parameter int CNT_W  = 16
);
    logic                         ttc_resync;
    logic                         rx_sync_done;
    logic [WORD_W-1:0]            rx_word;
    logic                         rx_kchar;
    logic                         rx_notintable;
    logic                         rx_disperr;
    logic                         en_prbs_test;
    logic                         rx_valid;
    logic                         rx_match;
    logic [(NWORDS-1)*WORD_W-1:0] frame_data;
    logic                         frame_strobe;
    logic [NWORDS-1:0]            cew;
    logic                         link_good;
    logic                         link_bad;
    logic                         link_had_err;
    logic [CNT_W-1:0]             err_count;
    logic [CNT_W-1:0]             notintable_count;
    logic [CNT_W-1:0]             disperr_count;

    modport master (
        output ttc_resync, rx_sync_done, rx_word, rx_kchar, rx_notintable, rx_disperr,
               en_prbs_test, rx_valid, rx_match,
        input  frame_data, frame_strobe, cew, link_good, link_bad, link_had_err,
               err_count, notintable_count, disperr_count
    );

    modport slave (
        input  ttc_resync, rx_sync_done, rx_word, rx_kchar, rx_notintable, rx_disperr,
               en_prbs_test, rx_valid, rx_match,
        output frame_data, frame_strobe, cew, link_good, link_bad, link_had_err,
               err_count, notintable_count, disperr_count
    );
endinterface

// File: rtl/gtx_rx_frame_monitor.sv
// Per-fiber GTX receive framer: K28.5 comma alignment, payload assembly, link FSM and saturating error counters.
// Define GTX_RX_PRBS_CHECK_EN to let err_count count PRBS mismatches while en_prbs_test is high.
module gtx_rx_frame_monitor #(
    parameter int WORD_W      = 16,
    parameter int NWORDS      = 4,
    parameter int CNT_W       = 16,
    parameter int LOCK_FRAMES = 8,
    parameter int BAD_FRAMES  = 4
) (
    input  logic                  rx_clk160,
    input  logic                  gtx_rx_reset,
    gtx_rx_frame_monitor_if.slave bus,
    output logic [1:0]            dbg_state_o
);
    localparam int PH_W = $clog2(NWORDS);
    localparam int LK_W = $clog2(LOCK_FRAMES + 1);
    localparam int BD_W = $clog2(BAD_FRAMES + 1);
    localparam int PL_W = (NWORDS - 1) * WORD_W;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d, phase_inc;
    logic [LK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [BD_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic              frame_bad_q, frame_bad_d;
    logic [PL_W-1:0]   shadow_q, shadow_d;
    logic [PL_W-1:0]   frame_data_q;
    logic              frame_strobe_q, frame_strobe_d;
    logic [NWORDS-1:0] cew_q, cew_d;
    logic              link_bad_q, link_had_err_q;
    logic [CNT_W-1:0]  err_cnt_q, ni_cnt_q, de_cnt_q;

    logic comma, word_err, active, last_phase;
    logic bad_frame, lost_lock, err_inc;

    assign comma      = bus.rx_kchar && (bus.rx_word[7:0] == 8'hBC);
    assign word_err   = bus.rx_notintable || bus.rx_disperr;
    assign active     = (state_q != ST_IDLE);
    assign last_phase = (phase_q == PH_LAST);
    assign phase_inc  = last_phase ? '0 : phase_q + 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge rx_clk160 or posedge gtx_rx_reset) begin
        if (gtx_rx_reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            lock_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            frame_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            lock_cnt_q  <= lock_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            frame_bad_q <= frame_bad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        lock_cnt_d  = lock_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        frame_bad_d = frame_bad_q;
        bad_frame   = 1'b0;
        lost_lock   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d    = '0;
                lock_cnt_d = '0;
                bad_cnt_d  = '0;
                if (bus.rx_sync_done) state_d = ST_HUNT;
            end
            ST_HUNT: begin
                bad_cnt_d   = '0;
                frame_bad_d = word_err;
                // lock_cnt == 0 means searching: any comma anywhere starts a candidate alignment.
                if (lock_cnt_q == '0) begin
                    if (comma) begin
                        phase_d    = PH_W'(1);
                        lock_cnt_d = LK_W'(1);
                    end else begin
                        phase_d = '0;
                    end
                end else begin
                    phase_d = phase_inc;
                    if (phase_q == '0) begin
                        if (comma) begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                        end else begin
                            lock_cnt_d = '0;
                            phase_d    = '0;
                        end
                    end
                end
                if (lock_cnt_d == LK_W'(LOCK_FRAMES)) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                phase_d = phase_inc;
                if (phase_q == '0) frame_bad_d = !comma || word_err;
                else               frame_bad_d = frame_bad_q || word_err;
                if (last_phase) begin
                    bad_frame = frame_bad_q || word_err;
                    bad_cnt_d = bad_frame ? bad_cnt_q + 1'b1 : '0;
                    if (bad_cnt_d == BD_W'(BAD_FRAMES)) begin
                        state_d    = ST_HUNT;
                        lost_lock  = 1'b1;
                        lock_cnt_d = '0;
                        bad_cnt_d  = '0;
                        phase_d    = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!bus.rx_sync_done) begin
            state_d     = ST_IDLE;
            phase_d     = '0;
            lock_cnt_d  = '0;
            bad_cnt_d   = '0;
            frame_bad_d = 1'b0;
        end
    end

    always_comb begin
        shadow_d       = shadow_q;
        frame_strobe_d = 1'b0;
        cew_d          = active ? ({{(NWORDS-1){1'b0}}, 1'b1} << phase_q) : '0;
        if (state_q == ST_LOCKED) begin
            if (phase_q != '0) shadow_d[(int'(phase_q) - 1) * WORD_W +: WORD_W] = bus.rx_word;
            frame_strobe_d = last_phase;
        end
    end

    always_ff @(posedge rx_clk160 or posedge gtx_rx_reset) begin
        if (gtx_rx_reset) begin
            shadow_q       <= '0;
            frame_data_q   <= '0;
            frame_strobe_q <= 1'b0;
            cew_q          <= '0;
        end else begin
            shadow_q       <= shadow_d;
            frame_strobe_q <= frame_strobe_d;
            cew_q          <= cew_d;
            // The last payload word lands in frame_data in the same edge it lands in the shadow.
            if (frame_strobe_d) frame_data_q <= shadow_d;
        end
    end

`ifdef GTX_RX_PRBS_CHECK_EN
    assign err_inc = bus.en_prbs_test
                   ? (active && (phase_q == '0) && bus.rx_valid && !bus.rx_match)
                   : bad_frame;
`else
    logic prbs_unused;
    assign prbs_unused = ^{bus.en_prbs_test, bus.rx_valid, bus.rx_match};
    assign err_inc     = bad_frame;
`endif

    always_ff @(posedge rx_clk160 or posedge gtx_rx_reset) begin
        if (gtx_rx_reset) begin
            err_cnt_q      <= '0;
            ni_cnt_q       <= '0;
            de_cnt_q       <= '0;
            link_bad_q     <= 1'b0;
            link_had_err_q <= 1'b0;
        end else if (bus.ttc_resync) begin
            err_cnt_q      <= '0;
            ni_cnt_q       <= '0;
            de_cnt_q       <= '0;
            link_bad_q     <= 1'b0;
            link_had_err_q <= 1'b0;
        end else begin
            err_cnt_q <= sat_inc(err_cnt_q, err_inc);
            ni_cnt_q  <= sat_inc(ni_cnt_q, active && bus.rx_notintable);
            de_cnt_q  <= sat_inc(de_cnt_q, active && bus.rx_disperr);
            if (lost_lock)           link_bad_q     <= 1'b1;
            if (active && word_err)  link_had_err_q <= 1'b1;
        end
    end

    assign bus.frame_data       = frame_data_q;
    assign bus.frame_strobe     = frame_strobe_q;
    assign bus.cew              = cew_q;
    assign bus.link_good        = (state_q == ST_LOCKED);
    assign bus.link_bad         = link_bad_q;
    assign bus.link_had_err     = link_had_err_q;
    assign bus.err_count        = err_cnt_q;
    assign bus.notintable_count = ni_cnt_q;
    assign bus.disperr_count    = de_cnt_q;
    assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_gtx_rx_frame_monitor.sv
// Directed bench for gtx_rx_frame_monitor (NWORDS=4, 16-bit words, 4-bit counters for saturation).
// Frames expected to strobe are queued when sent; a negedge monitor pops and compares each strobe.
module tb_gtx_rx_frame_monitor;
    localparam int WORD_W = 16;
    localparam int NWORDS = 4;
    localparam int CNT_W  = 4;
    localparam int PL_W   = (NWORDS - 1) * WORD_W;

    logic       rx_clk160 = 1'b0;
    logic       gtx_rx_reset;
    logic [1:0] dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [PL_W-1:0] exp_q[$];

    gtx_rx_frame_monitor_if #(.WORD_W(WORD_W), .NWORDS(NWORDS), .CNT_W(CNT_W)) bus ();

    gtx_rx_frame_monitor #(
        .WORD_W(WORD_W), .NWORDS(NWORDS), .CNT_W(CNT_W), .LOCK_FRAMES(8), .BAD_FRAMES(4)
    ) dut (
        .rx_clk160   (rx_clk160),
        .gtx_rx_reset(gtx_rx_reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 rx_clk160 = ~rx_clk160;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, 0 of 1 expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic word(input logic [15:0] w, input logic k, input logic ni, input logic de, input logic rs);
        bus.rx_word       = w;
        bus.rx_kchar      = k;
        bus.rx_notintable = ni;
        bus.rx_disperr    = de;
        bus.ttc_resync    = rs;
        @(posedge rx_clk160);
        #1;
        bus.ttc_resync    = 1'b0;
    endtask

    task automatic frame(input logic cm, input logic [15:0] p1, input logic [15:0] p2,
                         input logic [15:0] p3, input logic push, input logic [3:0] ni_m,
                         input logic [3:0] de_m, input logic rs);
        logic [15:0] w [4];
        w[0] = cm ? 16'h50BC : 16'h0000;
        w[1] = p1;
        w[2] = p2;
        w[3] = p3;
        if (push) exp_q.push_back({p3, p2, p1});
        for (int i = 0; i < 4; i++) word(w[i], (i == 0) && cm, ni_m[i], de_m[i], (i == 0) && rs);
    endtask

    task automatic good(input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] p3, input logic push);
        frame(1'b1, p1, p2, p3, push, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " link_good"},    64'(bus.link_good), 64'd0);
        check({tag, " link_bad"},     64'(bus.link_bad), 64'd0);
        check({tag, " link_had_err"}, 64'(bus.link_had_err), 64'd0);
        check({tag, " frame_strobe"}, 64'(bus.frame_strobe), 64'd0);
        check({tag, " frame_data"},   64'(bus.frame_data), 64'd0);
        check({tag, " cew"},          64'(bus.cew), 64'd0);
        check({tag, " err_count"},    64'(bus.err_count), 64'd0);
        check({tag, " ni_count"},     64'(bus.notintable_count), 64'd0);
        check({tag, " de_count"},     64'(bus.disperr_count), 64'd0);
    endtask

    always @(negedge rx_clk160) begin : monitor
        logic [PL_W-1:0] e;
        if (bus.frame_strobe === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL frame_strobe: unexpected strobe with frame_data %h, no frame expected", bus.frame_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.frame_data !== e) begin
                    miscompares++;
                    $display("FAIL frame_data: got %h expected %h", bus.frame_data, e);
                end
            end
        end
    end

    initial begin
        gtx_rx_reset      = 1'b1;
        bus.ttc_resync    = 1'b0;
        bus.rx_sync_done  = 1'b0;
        bus.rx_word       = '0;
        bus.rx_kchar      = 1'b0;
        bus.rx_notintable = 1'b0;
        bus.rx_disperr    = 1'b0;
        bus.en_prbs_test  = 1'b0;
        bus.rx_valid      = 1'b0;
        bus.rx_match      = 1'b0;
        repeat (3) @(posedge rx_clk160);
        #1;
        check_all_zero("reset");
        check("reset state", 64'(dbg_state), 64'd0);
        gtx_rx_reset     = 1'b0;
        bus.rx_sync_done = 1'b1;

        // Acquire lock
        word(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle->hunt", 64'(dbg_state), 64'd1);
        for (int f = 0; f < 7; f++) good(16'h1111, 16'h2222, 16'h3333, 1'b0);
        check("7 commas no lock", 64'(bus.link_good), 64'd0);
        exp_q.push_back(48'h333322221111);
        word(16'h50BC, 1'b1, 1'b0, 1'b0, 1'b0);
        check("8th comma lock", 64'(bus.link_good), 64'd1);
        check("cew ph0", 64'(bus.cew), 64'b0001);
        word(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cew ph1", 64'(bus.cew), 64'b0010);
        word(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cew ph2", 64'(bus.cew), 64'b0100);
        word(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cew ph3", 64'(bus.cew), 64'b1000);
        check("strobe latency", 64'(bus.frame_strobe), 64'd1);
        check("first frame", 64'(bus.frame_data), 64'h333322221111);
        word(16'h50BC, 1'b1, 1'b0, 1'b0, 1'b0);
        check("strobe one cycle", 64'(bus.frame_strobe), 64'd0);
        check("frame_data hold", 64'(bus.frame_data), 64'h333322221111);
        exp_q.push_back(48'h333322221111);
        for (int i = 0; i < 3; i++) word(16'(16'h1111 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        good(16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b1);
        good(16'h0001, 16'h8000, 16'h1234, 1'b1);
        check("no errors", 64'(bus.err_count), 64'd0);

        // Three bad frames then a good one keep lock
        for (int f = 0; f < 3; f++) frame(1'b0, 16'hBEEF, 16'h0F0F, 16'(f), 1'b1, 4'b0, 4'b0, 1'b0);
        good(16'h4321, 16'h8765, 16'hCBA9, 1'b1);
        check("lock held", 64'(bus.link_good), 64'd1);
        check("err after 3 bad", 64'(bus.err_count), 64'd3);
        frame(1'b1, 16'h0102, 16'h0304, 16'h0506, 1'b1, 4'b0, 4'b0, 1'b1);
        check("resync clears err", 64'(bus.err_count), 64'd0);
        for (int f = 0; f < 3; f++) frame(1'b0, 16'hDEAD, 16'h00FF, 16'(f + 7), 1'b1, 4'b0, 4'b0, 1'b0);
        check("bad_cnt cleared", 64'(bus.link_good), 64'd1);
        frame(1'b0, 16'hDEAD, 16'h00FF, 16'h0010, 1'b1, 4'b0, 4'b0, 1'b0);
        check("lock lost", 64'(bus.link_good), 64'd0);
        check("link_bad set", 64'(bus.link_bad), 64'd1);
        check("err after 4 bad", 64'(bus.err_count), 64'd4);

        // Word errors while re-locking in HUNT
        frame(1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b0, 4'b0000, 4'b0110, 1'b0);
        frame(1'b1, 16'h1111, 16'h2222, 16'h3333, 1'b0, 4'b1000, 4'b1010, 1'b0);
        for (int f = 0; f < 5; f++) good(16'h1111, 16'h2222, 16'h3333, 1'b0);
        check("7 frames relock pending", 64'(bus.link_good), 64'd0);
        good(16'h7777, 16'h8888, 16'h9999, 1'b1);
        check("relock", 64'(bus.link_good), 64'd1);
        check("disperr count", 64'(bus.disperr_count), 64'd4);
        check("notintable count", 64'(bus.notintable_count), 64'd1);
        check("had_err", 64'(bus.link_had_err), 64'd1);
        check("link_bad sticky", 64'(bus.link_bad), 64'd1);
        check("err unchanged in hunt", 64'(bus.err_count), 64'd4);

        // Resync in the same cycle as a disparity error
        exp_q.push_back(48'h666655554444);
        word(16'h50BC, 1'b1, 1'b0, 1'b1, 1'b1);
        check("resync err", 64'(bus.err_count), 64'd0);
        check("resync ni", 64'(bus.notintable_count), 64'd0);
        check("resync de wins", 64'(bus.disperr_count), 64'd0);
        check("resync link_bad", 64'(bus.link_bad), 64'd0);
        check("resync had_err wins", 64'(bus.link_had_err), 64'd0);
        check("resync keeps lock", 64'(bus.link_good), 64'd1);
        word(16'h4444, 1'b0, 1'b0, 1'b0, 1'b0);
        word(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        word(16'h6666, 1'b0, 1'b0, 1'b0, 1'b0);
        check("word_err bad frame", 64'(bus.err_count), 64'd1);
        good(16'hC0DE, 16'hFACE, 16'hB00C, 1'b1);

        // Saturation: 20 notintable words
        for (int f = 0; f < 6; f++) frame(1'b1, 16'h0A0A, 16'h0B0B, 16'(f), f < 4, 4'b1110, 4'b0, 1'b0);
        frame(1'b1, 16'h0A0A, 16'h0B0B, 16'h0C0C, 1'b0, 4'b0110, 4'b0, 1'b0);
        check("ni saturated", 64'(bus.notintable_count), 64'hF);
        check("de after clear", 64'(bus.disperr_count), 64'd0);
        check("err after sat", 64'(bus.err_count), 64'd5);
        check("sat lock lost", 64'(bus.link_good), 64'd0);
        check("sat link_bad", 64'(bus.link_bad), 64'd1);

        // Reset in the middle of a locked frame
        for (int f = 0; f < 5; f++) good(16'h1357, 16'h2468, 16'h9ABC, f == 4);
        check("pre-reset lock", 64'(bus.link_good), 64'd1);
        word(16'h50BC, 1'b1, 1'b0, 1'b0, 1'b0);
        word(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
        gtx_rx_reset = 1'b1;
        #1;
        check_all_zero("async reset");
        @(posedge rx_clk160);
        @(posedge rx_clk160);
        #1;
        gtx_rx_reset = 1'b0;
        word(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 7; f++) good(16'h1111, 16'h2222, 16'h3333, 1'b0);
        check("post-reset 7 frames", 64'(bus.link_good), 64'd0);
        exp_q.push_back(48'h333322221111);
        word(16'h50BC, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post-reset lock", 64'(bus.link_good), 64'd1);
        for (int i = 0; i < 3; i++) word(16'(16'h1111 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0);

        // PRBS mismatches on 5 frames
        bus.en_prbs_test = 1'b1;
        bus.rx_valid     = 1'b1;
        bus.rx_match     = 1'b0;
        for (int f = 0; f < 5; f++) good(16'h0F0F, 16'hF0F0, 16'(f + 1), 1'b1);
        bus.en_prbs_test = 1'b0;
        bus.rx_valid     = 1'b0;
`ifdef GTX_RX_PRBS_CHECK_EN
        check("prbs err_count", 64'(bus.err_count), 64'd5);
`else
        check("prbs err_count", 64'(bus.err_count), 64'd0);
`endif
        check("prbs lock", 64'(bus.link_good), 64'd1);

        repeat (4) @(posedge rx_clk160);
        #1;
        check("frames outstanding", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
